// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: program counter and fetch/retire controller with next-PC select and misalignment trap
module pc_fetch_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            retire,
    input  logic [6:0]      opcode,
    input  logic            and_out,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     instret
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [XLEN-1:0] CLR_LSB = {{(XLEN-1){1'b1}}, 1'b0};
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, trap_pc_q, trap_pc_d, target;
    logic [31:0]     instr_q, instr_d, instret_q, instret_d;
    logic            trap_q, trap_d, misaligned;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = state_q == FETCH;
    assign instr_valid = state_q == EXEC;
    assign instr       = instr_q;
    assign instret     = instret_q;
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;
    // Next-PC select; jumps and taken branches go pc-relative, JALR is register-relative with bit 0 cleared
    always_comb begin
        target = ((opcode == OP_BRANCH && and_out) || opcode == OP_JAL) ? pc_q + imm :
                 opcode == OP_JALR ? (rs1_val + imm) & CLR_LSB : pc_plus4;
        misaligned = |target[1:0];
    end
    // FSM next state: latch the fetched word, then redirect the PC when the instruction retires
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        trap_d    = 1'b0;
        trap_pc_d = trap_pc_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ready) begin
                instr_d = imem_rdata;
                state_d = EXEC;
            end
            EXEC:  if (retire) begin
                state_d   = FETCH;
                instret_d = instret_q + 32'd1;
                pc_d      = misaligned ? TRAP_VEC : target;
                trap_d    = misaligned;
                trap_pc_d = misaligned ? pc_q : trap_pc_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers with synchronous reset that abandons any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            instr_q   <= 32'h0000_0013;
            instret_q <= '0;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end
endmodule

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

Sequential program-counter and fetch controller for the RISC-V core. It owns the architectural PC, issues instruction-memory fetches over a request/ready handshake, and holds each fetched instruction until the execute path retires it. On retire it selects the next PC:

- branch taken when the branch condition is true;
- JAL;
- JALR;
- PC+4 otherwise.

A misaligned target redirects to a trap vector instead.

## Interface
- XLEN, 32, datapath/address width
- RESET_VEC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned control-transfer target

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request, valid while in FETCH
- imem_addr  out  XLEN  fetch address, equals pc
- imem_ready  in  1  memory accepts request and presents imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  latched instruction for decode/execute
- instr_valid  out  1  instr is valid and awaiting retire
- retire  in  1  execute path finished current instruction
- opcode  in  7  opcode of current instruction (from decode)
- and_out  in  1  branch condition result (branch & ALU compare)
- imm  in  XLEN  sign-extended immediate (B/J/I type)
- rs1_val  in  XLEN  rs1 operand for JALR
- pc  out  XLEN  current PC
- pc_plus4  out  XLEN  pc+4, link value for JAL/JALR
- trap  out  1  one-cycle pulse on misaligned target
- trap_pc  out  XLEN  PC of instruction that caused last trap
- instret  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC.
- Reset values (applied when rst=1 at an edge):
  - state=IDLE, pc=RESET_VEC, instr=32'h0000_0013 (NOP);
  - instr_valid=0, imem_req=0, trap=0, trap_pc=0, instret=0.
- IDLE: no request. Advances to FETCH next cycle unconditionally.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready=1. On that edge: instr<=imem_rdata, go to EXEC.
- EXEC: instr_valid=1. Waits for retire=1. On that edge:
  - compute next target (below) and instret<=instret+1;
  - go to FETCH, or to FETCH with pc=TRAP_VEC on a trap.
- Next-PC select, evaluated only on retire:
  - opcode 7'b1100011 and and_out=1 -> pc+imm;
  - opcode 7'b1100011 and and_out=0 -> pc+4;
  - opcode 7'b1101111 (JAL) -> pc+imm;
  - opcode 7'b1100111 (JALR) -> (rs1_val+imm) & ~1;
  - any other opcode -> pc+4.
- Misalignment: if the selected target has bits[1:0] != 0:
  - pc<=TRAP_VEC, trap_pc<=pc of the retiring instruction, trap=1 for exactly the next cycle;
  - instret still increments.
- Arithmetic: all PC adds are modulo 2^XLEN. pc=32'hFFFF_FFFC with pc+4 wraps to 0. instret wraps 32'hFFFF_FFFF -> 0.
- pc_plus4 is combinational pc+4, always valid.

## Timing
- Minimum 2 cycles per instruction: FETCH with imem_ready=1, then EXEC with retire=1.
- First imem_req rises 2 cycles after rst deasserts: IDLE then FETCH.
- pc, instr, and instr_valid update only on state-transition edges. They are otherwise stable.
- Stray handshake inputs:
  - retire outside EXEC is ignored;
  - imem_ready outside FETCH is ignored;
  - imem_rdata is sampled only when FETCH and imem_ready=1.
- instr_valid drops in the same edge that retire is accepted. It is 0 throughout FETCH.
- trap asserts in the cycle after the retire edge, coincident with the first FETCH of TRAP_VEC.
- rst=1 mid-FETCH or mid-EXEC: the request is abandoned at that edge and all reset values apply. No retire or instret update occurs on that edge.

## Test plan
- Reset/fetch: release rst, imem_ready=1, rdata=32'h00500093.
  - imem_req high 2 cycles after release with addr=0;
  - next cycle instr=32'h00500093 and instr_valid=1.
- Sequential + stall: opcode 7'b0110011, retire held low 3 cycles then high.
  - instr_valid stays 1 during the stall;
  - pc 0 -> 4, instret=1;
  - imem_ready low 2 cycles keeps imem_addr=4 stable.
- Branch: pc=8, opcode 7'b1100011, imm=16.
  - and_out=1 -> next fetch addr 24;
  - repeat at pc=24 with and_out=0 -> 28.
- JAL/JALR: pc=32, JAL imm=-32 -> addr 0, pc_plus4 was 36.
  - JALR with rs1_val=101, imm=3 -> target 104 (bit0 cleared).
- Misaligned trap: pc=40, JAL imm=6.
  - pc=TRAP_VEC (0x100), trap=1 for one cycle, trap_pc=40, instret incremented.
- Wrap/reset: pc=32'hFFFF_FFFC, non-control opcode -> next addr 0.
  - Assert rst during a subsequent FETCH -> pc=0, imem_req=0, instret=0 next cycle.
